// File: rtl/cofre_pkg.sv
// Shared definitions for the vault interface: state encoding, idle symbol
// and the default combination.
package cofre_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESS   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WAIT_Y  = 2'd3
  } state_e;

  localparam logic [1:0] SYM_IDLE           = 2'b00;
  localparam logic [9:0] COFRE_CODE_DEFAULT = 10'b01_11_01_01_10;

  // Largest of three phase lengths; sizes the shared tick counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/cofre_code_sender_tick_counter.sv
// Loadable, non-wrapping down-counter with a zero flag. The sequencer loads
// it on each phase entry with (phase length - 1) and leaves when it hits 0.
module tick_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins, otherwise decrement and saturate at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/cofre_code_sender.sv
// Drives the vault lock button bus with a stored combination (press HOLD,
// release GAP per symbol), then watches the lock's door-open output during
// the final press and up to TIMEOUT cycles afterwards.
module cofre_code_sender
  import cofre_pkg::*;
#(
  parameter int N_SYM   = 5,
  parameter int HOLD    = 1,
  parameter int GAP     = 3,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*N_SYM-1:0] code,
  input  logic               y,
  output logic [1:0]         x,
  output logic               busy,
  output logic               done,
  output logic               ok,
  output logic               err
);

  localparam int CW = $clog2(max3(HOLD, GAP, TIMEOUT) + 1);
  localparam int IW = $clog2(N_SYM + 1);

  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_SYM - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);

  // Symbol i of a code word; symbol 0 is the most significant pair.
  function automatic logic [1:0] sym_at(input logic [2*N_SYM-1:0] c,
                                        input logic [IW-1:0]      i);
    logic [2*N_SYM-1:0] sh;
    sh = c >> (2 * (N_SYM - 1 - int'(i)));
    return sh[1:0];
  endfunction

  // A code is unusable if any symbol is the idle (no button) symbol.
  function automatic logic has_idle_sym(input logic [2*N_SYM-1:0] c);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N_SYM; k++) begin
      if (c[2*k +: 2] == SYM_IDLE) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  state_e             state_q, state_d;
  logic [2*N_SYM-1:0] code_q,  code_d;
  logic [IW-1:0]      idx_q,   idx_d;
  logic [1:0]         x_q,     x_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               ok_q,    ok_d;
  logic               err_q,   err_d;

  logic               cnt_load_s;
  logic [CW-1:0]      cnt_val_s;
  logic               cnt_dec_s;
  logic               cnt_zero_s;
  logic               last_sym_s;

  tick_counter #(.W(CW)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load_s),
    .load_val (cnt_val_s),
    .dec      (cnt_dec_s),
    .zero     (cnt_zero_s)
  );

  assign last_sym_s = (idx_q == LAST_IDX);

  // Sequencer next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    x_d        = SYM_IDLE;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = 1'b0;
    cnt_load_s = 1'b0;
    cnt_val_s  = {CW{1'b0}};
    cnt_dec_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (has_idle_sym(code)) begin
            err_d = 1'b1;
          end else begin
            code_d     = code;
            ok_d       = 1'b0;
            idx_d      = {IW{1'b0}};
            x_d        = sym_at(code, {IW{1'b0}});
            busy_d     = 1'b1;
            state_d    = ST_PRESS;
            cnt_load_s = 1'b1;
            cnt_val_s  = HOLD_LD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESS: begin
        x_d = sym_at(code_q, idx_q);
        if (last_sym_s && y) begin
          // Door opened while the final symbol is still held.
          x_d     = SYM_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_zero_s) begin
          x_d        = SYM_IDLE;
          cnt_load_s = 1'b1;
          if (last_sym_s) begin
            cnt_val_s = TIMEOUT_LD;
            state_d   = ST_WAIT_Y;
          end else begin
            cnt_val_s = GAP_LD;
            state_d   = ST_RELEASE;
          end
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      ST_RELEASE: begin
        if (cnt_zero_s) begin
          idx_d      = idx_q + IDX_ONE;
          x_d        = sym_at(code_q, idx_q + IDX_ONE);
          state_d    = ST_PRESS;
          cnt_load_s = 1'b1;
          cnt_val_s  = HOLD_LD;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      ST_WAIT_Y: begin
        if (y) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_zero_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          ok_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          cnt_dec_s = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        idx_d   = {IW{1'b0}};
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched code, symbol index and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= {(2*N_SYM){1'b0}};
      idx_q   <= {IW{1'b0}};
      x_q     <= SYM_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign x    = x_q;
  assign busy = busy_q;
  assign done = done_q;
  assign ok   = ok_q;
  assign err  = err_q;

endmodule

// File: tb/tb_cofre_code_sender.sv
// Self-checking bench for cofre_code_sender: a table of sequences plus
// hand-written reset-abort and back-to-back sequences. Expected done/ok
// results go into a scoreboard queue at start and are popped when done fires.
module tb_cofre_code_sender;

  localparam int NS    = 5;
  localparam int HOLDT = 1;
  localparam int GAPT  = 3;
  localparam int P     = HOLDT + GAPT;
  localparam logic [9:0] DEF_CODE = 10'b01_11_01_01_10;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [9:0] code;
  logic       y;
  logic [1:0] x;
  logic       busy, done, ok, err;
  logic       y_force;
  logic       mealy_en;

  int n_vec  = 0;
  int n_fail = 0;
  bit last_ok;

  typedef struct {
    logic [9:0] code;
    int         y_cyc;
    bit         mealy;
    int         exp_done;
    bit         exp_ok;
    bit         exp_err;
  } vec_t;

  typedef struct {
    int cyc;
    bit ok;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  always #5 clk = ~clk;

  // Lock model: door opens on symbol 10 when enabled, or when forced.
  assign y = y_force | (mealy_en & (x == 2'b10));

  cofre_code_sender #(.N_SYM(NS), .HOLD(HOLDT), .GAP(GAPT), .TIMEOUT(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .code  (code),
    .y     (y),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .ok    (ok),
    .err   (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected x in cycle c of a sequence whose done pulse is at end_c.
  function automatic logic [1:0] exp_x(input int c, input logic [9:0] cd, input int end_c);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 0; i < NS; i++) begin
      if (c < end_c && c >= 1 + i*P && c <= i*P + HOLDT) r = cd[2*(NS-1-i) +: 2];
    end
    return r;
  endfunction

  task automatic monitor(input int c);
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL done_unexpected: done=1 at cycle %0d, expected 0", c);
      end else begin
        e = sb.pop_front();
        check("done_cycle", c, e.cyc);
        check("done_ok", int'(ok), int'(e.ok));
      end
    end
  endtask

  task automatic drain_check();
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL done_missing: %0d pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   last_c;
    exp_t e;
    tick();
    start    = 1'b1;
    code     = v.code;
    mealy_en = v.mealy;
    y_force  = 1'b0;
    if (!v.exp_err) begin
      e.cyc = v.exp_done;
      e.ok  = v.exp_ok;
      sb.push_back(e);
    end
    last_c = v.exp_err ? 6 : v.exp_done + 1;
    for (int c = 1; c <= last_c; c++) begin
      tick();
      start   = 1'b0;
      y_force = (c == v.y_cyc);
      #3;
      if (v.exp_err) begin
        check("err_pulse", int'(err), int'(c == 1));
        check("x_err", int'(x), 0);
        check("busy_err", int'(busy), 0);
        if (c == 1) check("ok_held_err", int'(ok), int'(last_ok));
      end else begin
        check("x", int'(x), int'(exp_x(c, v.code, v.exp_done)));
        check("busy", int'(busy), int'(c < v.exp_done));
        if (c < v.exp_done) check("ok_cleared", int'(ok), 0);
        if (c == v.exp_done + 1) check("ok_hold", int'(ok), int'(v.exp_ok));
      end
      monitor(c);
    end
    y_force  = 1'b0;
    mealy_en = 1'b0;
    drain_check();
    if (!v.exp_err) last_ok = v.exp_ok;
  endtask

  initial begin
    exp_t e;
    int   rc;

    rst      = 1'b1;
    start    = 1'b1;
    code     = DEF_CODE;
    y_force  = 1'b0;
    mealy_en = 1'b0;
    last_ok  = 1'b0;

    tbl[0] = '{DEF_CODE,          -1, 1'b1, 18, 1'b1, 1'b0};
    tbl[1] = '{10'b01_00_01_01_10, -1, 1'b0, -1, 1'b0, 1'b1};
    tbl[2] = '{DEF_CODE,          -1, 1'b0, 34, 1'b0, 1'b0};
    tbl[3] = '{DEF_CODE,          20, 1'b0, 21, 1'b1, 1'b0};
    tbl[4] = '{DEF_CODE,          33, 1'b0, 34, 1'b1, 1'b0};
    tbl[5] = '{DEF_CODE,           5, 1'b0, 34, 1'b0, 1'b0};
    tbl[6] = '{10'b11_10_01_11_11, -1, 1'b1, 34, 1'b0, 1'b0};
    tbl[7] = '{10'b01_01_01_01_00, -1, 1'b0, -1, 1'b0, 1'b1};

    // Reset held two cycles with start high.
    tick();
    tick();
    #3;
    check("rst_x", int'(x), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ok", int'(ok), 0);
    check("rst_err", int'(err), 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    #3;
    check("rst_no_start", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i]);
    end

    // Early y, second start while busy, then reset mid-sequence.
    tick();
    start = 1'b1;
    code  = DEF_CODE;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start   = (c == 3);
      code    = (c == 3) ? 10'b11_11_11_11_11 : DEF_CODE;
      y_force = (c == 5);
      rst     = (c == 6);
      #3;
      if (c == 4) check("abort_restart_ignored", int'(x), 0);
      if (c == 5) check("abort_x_c5", int'(x), 3);
      if (c == 5) check("abort_busy_c5", int'(busy), 1);
      if (c >= 7) check("abort_x", int'(x), 0);
      if (c >= 7) check("abort_busy", int'(busy), 0);
      monitor(c);
    end
    start   = 1'b0;
    rst     = 1'b0;
    y_force = 1'b0;
    drain_check();

    // Back-to-back: start held in the done cycle of the first sequence.
    tick();
    start    = 1'b1;
    code     = DEF_CODE;
    mealy_en = 1'b1;
    e.cyc    = 18;
    e.ok     = 1'b1;
    sb.push_back(e);
    for (int c = 1; c <= 37; c++) begin
      tick();
      start = (c == 18);
      #3;
      rc = (c <= 18) ? c : c - 18;
      check("b2b_x", int'(x), int'(exp_x(rc, DEF_CODE, 18)));
      check("b2b_busy", int'(busy), int'(rc >= 1 && rc < 18));
      if (c == 19) check("b2b_x_c19", int'(x), 1);
      monitor(c);
      if (c == 18) begin
        e.cyc = 36;
        e.ok  = 1'b1;
        sb.push_back(e);
      end
    end
    start    = 1'b0;
    mealy_en = 1'b0;
    drain_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
